// File: rtl/flag_shadow_pkg.sv
// Shared definitions for the status-flag register and its nested-interrupt shadow stack.
package flag_shadow_pkg;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;

    typedef enum logic [1:0] {
        STK_IDLE = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2,
        STK_SWAP = 2'd3
    } stk_op_t;

endpackage

// File: rtl/flag_bit.sv
// One status flag flop: restore from the shadow stack beats CLR, which beats SET, which beats LD.
module flag_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic alu_val,
    input  logic ld,
    input  logic set,
    input  logic clr,
    input  logic restore,
    input  logic restore_val,
    output logic q
);

    logic q_reg;
    logic q_next;

    always_comb begin
        q_next = q_reg;
        if (restore) begin
            q_next = restore_val;
        end else if (clr) begin
            q_next = 1'b0;
        end else if (set) begin
            q_next = 1'b1;
        end else if (ld) begin
            q_next = alu_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/flag_shadow_stack.sv
// Status-flag register with a DEPTH-level LIFO shadow stack saved on interrupt entry and restored on RETI.
module flag_shadow_stack
    import flag_shadow_pkg::*;
#(
    parameter int NUM_FLAGS = 2,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_FLAGS-1:0]       flg_alu,
    input  logic [NUM_FLAGS-1:0]       flg_ld,
    input  logic [NUM_FLAGS-1:0]       flg_set,
    input  logic [NUM_FLAGS-1:0]       flg_clr,
    input  logic                       shad_push,
    input  logic                       shad_pop,
    input  logic                       err_clr,
    output logic [NUM_FLAGS-1:0]       flg_out,
    output logic [$clog2(DEPTH+1)-1:0] shad_cnt,
    output logic                       shad_full,
    output logic                       shad_empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int CW = $clog2(DEPTH+1);

    logic [NUM_FLAGS-1:0] stack_reg [DEPTH];
    logic [CW-1:0]        cnt_reg;
    logic [CW-1:0]        cnt_next;
    logic                 ovf_reg;
    logic                 unf_reg;
    logic                 ovf_next;
    logic                 unf_next;

    logic                 full;
    logic                 empty;
    stk_op_t              op;
    logic [CW-1:0]        top_idx;
    logic [CW-1:0]        wr_idx;
    logic                 wr_en;
    logic                 restore;
    logic [NUM_FLAGS-1:0] top_val;

    assign full    = (cnt_reg == CW'(DEPTH));
    assign empty   = (cnt_reg == '0);
    assign top_idx = cnt_reg - CW'(1);

    // Push+pop on an empty stack degrades to a plain push; push+pop on a non-empty one is an exchange.
    always_comb begin
        op = STK_IDLE;
        if (shad_push && shad_pop) begin
            op = empty ? STK_PUSH : STK_SWAP;
        end else if (shad_push) begin
            op = full ? STK_IDLE : STK_PUSH;
        end else if (shad_pop) begin
            op = empty ? STK_IDLE : STK_POP;
        end
    end

    always_comb begin
        top_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == CW'(i)) begin
                top_val = stack_reg[i];
            end
        end
    end

    assign wr_en   = (op == STK_PUSH) || (op == STK_SWAP);
    assign wr_idx  = (op == STK_SWAP) ? top_idx : cnt_reg;
    assign restore = (op == STK_POP) || (op == STK_SWAP);

    always_comb begin
        cnt_next = cnt_reg;
        case (op)
            STK_PUSH: cnt_next = cnt_reg + CW'(1);
            STK_POP:  cnt_next = cnt_reg - CW'(1);
            default:  cnt_next = cnt_reg;
        endcase
    end

    // A new error in the same cycle as err_clr keeps the sticky flag set.
    always_comb begin
        ovf_next = (ovf_reg && !err_clr) || (shad_push && !shad_pop && full);
        unf_next = (unf_reg && !err_clr) || (shad_pop && empty);
    end

    generate
        for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
            flag_bit u_flag_bit (
                .clk         (clk),
                .rst_n       (rst_n),
                .alu_val     (flg_alu[gi]),
                .ld          (flg_ld[gi]),
                .set         (flg_set[gi]),
                .clr         (flg_clr[gi]),
                .restore     (restore),
                .restore_val (top_val[gi]),
                .q           (flg_out[gi])
            );
        end
    endgenerate

    // The stack captures the pre-edge flag vector; vacated entries keep their data after a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_reg[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    stack_reg[i] <= flg_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    assign shad_cnt   = cnt_reg;
    assign shad_full  = full;
    assign shad_empty = empty;
    assign ovf_err    = ovf_reg;
    assign unf_err    = unf_reg;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Self-checking bench for flag_shadow_stack: vector table, corner-case sequences, random run vs. queue model.
module tb_flag_shadow_stack;
    import flag_shadow_pkg::*;

    localparam int NF    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] flg_alu = '0, flg_ld = '0, flg_set = '0, flg_clr = '0;
    logic          shad_push = 1'b0, shad_pop = 1'b0, err_clr = 1'b0;
    logic [NF-1:0] flg_out;
    logic [CW-1:0] shad_cnt;
    logic          shad_full, shad_empty, ovf_err, unf_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the stack is a queue whose back is the top.
    logic [NF-1:0] m_flg;
    logic [NF-1:0] m_stk[$];
    logic          m_ovf, m_unf;

    always #5 clk = ~clk;

    flag_shadow_stack #(.NUM_FLAGS(NF), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flg_alu    (flg_alu),
        .flg_ld     (flg_ld),
        .flg_set    (flg_set),
        .flg_clr    (flg_clr),
        .shad_push  (shad_push),
        .shad_pop   (shad_pop),
        .err_clr    (err_clr),
        .flg_out    (flg_out),
        .shad_cnt   (shad_cnt),
        .shad_full  (shad_full),
        .shad_empty (shad_empty),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    typedef struct {
        logic          push, pop, eclr;
        logic [NF-1:0] alu, ld, set, clr;
        logic [NF-1:0] exp_flg;
        int            exp_cnt;
        logic          exp_ovf, exp_unf;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [NF-1:0] ef, input int ec,
                             input logic eo, input logic eu);
        check({tag, " flg"}, int'(flg_out), int'(ef));
        check({tag, " cnt"}, int'(shad_cnt), ec);
        check({tag, " full"}, int'(shad_full), int'(ec == DEPTH));
        check({tag, " empty"}, int'(shad_empty), int'(ec == 0));
        check({tag, " ovf"}, int'(ovf_err), int'(eo));
        check({tag, " unf"}, int'(unf_err), int'(eu));
        $display("%s: push=%0b pop=%0b eclr=%0b -> flg=%b cnt=%0d ovf=%0b unf=%0b",
                 tag, shad_push, shad_pop, err_clr, flg_out, shad_cnt, ovf_err, unf_err);
    endtask

    task automatic model_reset();
        m_flg = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic push, input logic pop, input logic eclr,
                              input logic [NF-1:0] alu, ld, set, clr);
        logic [NF-1:0] nf;
        logic          new_ovf, new_unf;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        for (int b = 0; b < NF; b++) begin
            if (clr[b])      nf[b] = 1'b0;
            else if (set[b]) nf[b] = 1'b1;
            else if (ld[b])  nf[b] = alu[b];
            else             nf[b] = m_flg[b];
        end
        if (push && pop && m_stk.size() > 0) begin
            nf = m_stk[m_stk.size()-1];
            m_stk[m_stk.size()-1] = m_flg;
        end else begin
            if (pop) begin
                if (m_stk.size() > 0) nf = m_stk.pop_back();
                else new_unf = 1'b1;
            end
            if (push) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(m_flg);
                else new_ovf = 1'b1;
            end
        end
        m_flg = nf;
        m_ovf = new_ovf || (m_ovf && !eclr);
        m_unf = new_unf || (m_unf && !eclr);
    endtask

    task automatic drive(input logic push, input logic pop, input logic eclr,
                         input logic [NF-1:0] alu, ld, set, clr);
        shad_push = push; shad_pop = pop; err_clr = eclr;
        flg_alu = alu; flg_ld = ld; flg_set = set; flg_clr = clr;
        model_step(push, pop, eclr, alu, ld, set, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        shad_push = 1'b0; shad_pop = 1'b0; err_clr = 1'b0;
        flg_alu = '0; flg_ld = '0; flg_set = '0; flg_clr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_flg, m_stk.size(), m_ovf, m_unf);
    endtask

    initial begin
        //            push  pop   eclr  alu    ld     set    clr    flg    cnt ovf   unf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0};

        do_reset();
        check_all("reset", 2'b00, 0, 1'b0, 1'b0);

        // Table-driven vectors with hand-computed expectations.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].eclr,
                  vecs[i].alu, vecs[i].ld, vecs[i].set, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].exp_flg, vecs[i].exp_cnt,
                      vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // LIFO fill to full, overflow push, then unwind.
        do_reset();
        drive(0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b10, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);
        check_all("fill4", 2'b00, 4, 1'b0, 1'b0);
        drive(1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_all("push_full", 2'b00, 4, 1'b1, 1'b0);
        drive(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_all("pop1", 2'b11, 3, 1'b1, 1'b0);
        drive(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_all("pop2", 2'b10, 2, 1'b1, 1'b0);
        drive(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_all("pop3", 2'b01, 1, 1'b1, 1'b0);
        drive(0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        check_all("pop4", 2'b00, 0, 1'b0, 1'b0);

        // Exchange: top entry 10, flags 01.
        do_reset();
        drive(0, 0, 0, 2'b10, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        check_all("swap_pre", 2'b01, 1, 1'b0, 1'b0);
        drive(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_all("swap", 2'b10, 1, 1'b0, 1'b0);
        drive(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        check_all("swap_top", 2'b01, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with two levels stacked.
        drive(1, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        drive(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        drive(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        drive(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b10, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        check_all("pre_areset", 2'b01, 2, 1'b0, 1'b1);
        shad_push = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("areset", 2'b00, 0, 1'b0, 1'b0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("areset_hold", 2'b00, 0, 1'b0, 1'b0);

        // Randomized run against the queue model.
        for (int n = 0; n < 400; n++) begin
            logic p, q, e;
            p = ($urandom_range(0, 2) == 0);
            q = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 7) == 0);
            drive(p, q, e, NF'($urandom), NF'($urandom), NF'($urandom & $urandom),
                  NF'($urandom & $urandom));
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
